controle_jogo: RTL and testbench
================================

CONTROLE_JOGO -- requirements
Module: controle_jogo

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of cycles spent waiting in a verification state.
REQ-002 Parameter MAX_ERROS, default 3: number of rejected moves that ends the game in defeat.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The ports SHALL be:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- entradaValida  input  1  one-cycle pulse; entrada holds a player digit.
- entrada  input  4  player digit; legal range 1..9.
- novoJogo  input  1  one-cycle pulse; restarts from fimJogo.
- verificaPosPronto  input  1  position checker result valid.
- posLivre  input  1  qualifies verificaPosPronto; 1 means the cell is editable.
- verificaJogoPronto  input  1  move checker result valid.
- jogadaValida  input  1  qualifies verificaJogoPronto; 1 means the move is legal.
- tabuleiroCompleto  input  1  qualifies verificaJogoPronto; 1 means the board is full.
- estadoJogo  output  3  current game state, consumed by the state demultiplexer.
- linha, coluna, valor  output  4 each  latched move coordinates and digit.
- escreveCelula  output  1  one-cycle pulse that commits valor at (linha, coluna).
- entradaInvalida  output  1  one-cycle pulse on an out-of-range digit.
- erroTimeout  output  1  one-cycle pulse on a verification timeout.
- erros  output  2  count of rejected moves.
- jogadas  output  7  count of accepted moves, 0..81.
- vitoria, derrota  output  1 each  game result, valid while in fimJogo.

Function
REQ-005 estadoJogo encoding SHALL be: recebeLinha=000, recebeColuna=001, verificaPos=010, recebeValor=011, verificaJogo=100, fimJogo=101. The output is registered and equals the current state.
REQ-006 recebeLinha: an entradaValida pulse with entrada in 1..9 SHALL latch linha and move to recebeColuna on the next edge.
REQ-007 recebeColuna: an entradaValida pulse with entrada in 1..9 SHALL latch coluna and move to verificaPos.
REQ-008 In recebeLinha, recebeColuna and recebeValor, an entradaValida pulse with entrada of 0 or 10..15 SHALL:
- pulse entradaInvalida the next cycle;
- leave the state unchanged;
- leave all latched values unchanged.
REQ-009 entradaValida SHALL be ignored in verificaPos, verificaJogo and fimJogo.
REQ-010 verificaPos, on verificaPosPronto:
- posLivre=1 moves to recebeValor;
- posLivre=0 returns to recebeLinha, and erros is not changed.
REQ-011 recebeValor: an entradaValida pulse with a valid digit SHALL latch valor and move to verificaJogo.
REQ-012 verificaJogo, on verificaJogoPronto with jogadaValida=1:
- pulse escreveCelula for exactly one cycle;
- increment jogadas;
- move to fimJogo with vitoria=1 if tabuleiroCompleto=1, otherwise to recebeLinha.
REQ-013 verificaJogo, on verificaJogoPronto with jogadaValida=0:
- increment erros;
- if the new erros value equals MAX_ERROS, move to fimJogo with derrota=1;
- otherwise return to recebeLinha.
REQ-014 The timeout counter SHALL:
- clear on entry to verificaPos or verificaJogo;
- increment every cycle spent in that state.
REQ-015 If TIMEOUT cycles elapse without the relevant Pronto signal, the block SHALL return to recebeLinha and pulse erroTimeout; erros is not changed.
REQ-016 A Pronto signal arriving in the same cycle the timeout expires SHALL take priority over the timeout.
REQ-017 fimJogo SHALL hold every output until novoJogo or reset.
REQ-018 novoJogo in fimJogo SHALL have the same effect as reset; novoJogo in any other state SHALL be ignored.
REQ-019 An illegal state encoding (110 or 111) SHALL go to recebeLinha on the next edge, and counters are not changed.
REQ-020 jogadas SHALL saturate at 81.
REQ-021 erros SHALL never exceed MAX_ERROS.
REQ-022 Pronto inputs SHALL be ignored outside their own verification state.
REQ-023 Latency SHALL be exactly one clock cycle from any accepted input event to the state change and the associated pulse.

Reset
REQ-024 On reset, the block SHALL set:
- estadoJogo=000 (recebeLinha);
- linha, coluna and valor to 0;
- erros, jogadas and the timeout counter to 0;
- all pulse outputs, vitoria and derrota to 0.
REQ-025 Reset SHALL take effect from any state, including mid-verification, and SHALL override every other input in the same cycle.

Verification
REQ-026 Accepted move: enter digits 3, 5, then posLivre=1, then digit 7, then jogadaValida=1 -> state sequence 000→001→010→011→100→000; linha=3, coluna=5, valor=7; escreveCelula pulses once; jogadas=1.
REQ-027 Invalid digit: in recebeLinha, entrada=0 and then entrada=12 -> two entradaInvalida pulses; state stays 000; linha unchanged.
REQ-028 Defeat: three consecutive moves with jogadaValida=0 -> erros counts 1, 2, 3; the third enters 101 with derrota=1; novoJogo then gives estadoJogo=000 and erros=0.
REQ-029 Timeout: hold verificaPosPronto=0 for 16 cycles in 010 -> erroTimeout pulses and state returns to 000; a Pronto arriving on cycle 16 is honoured instead.
REQ-030 Victory: with jogadas=80, a legal move with tabuleiroCompleto=1 -> state 101, vitoria=1, jogadas=81; later entradaValida pulses are ignored.
REQ-031 Reset mid-operation: assert reset while in verificaJogo -> next cycle estadoJogo=000 and all counters are 0.

Source files
------------

// File: rtl/controle_jogo.sv
// Sudoku move controller: collects row, column and digit, waits on the position
// and move checkers (with timeout), and tracks accepted moves, errors and game end.
module controle_jogo #(
  parameter int TIMEOUT   = 16,
  parameter int MAX_ERROS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entradaValida,
  input  logic [3:0] entrada,
  input  logic       novoJogo,
  input  logic       verificaPosPronto,
  input  logic       posLivre,
  input  logic       verificaJogoPronto,
  input  logic       jogadaValida,
  input  logic       tabuleiroCompleto,
  output logic [2:0] estadoJogo,
  output logic [3:0] linha,
  output logic [3:0] coluna,
  output logic [3:0] valor,
  output logic       escreveCelula,
  output logic       entradaInvalida,
  output logic       erroTimeout,
  output logic [1:0] erros,
  output logic [6:0] jogadas,
  output logic       vitoria,
  output logic       derrota
);

  typedef enum logic [2:0] {
    RECEBE_LINHA  = 3'b000,
    RECEBE_COLUNA = 3'b001,
    VERIFICA_POS  = 3'b010,
    RECEBE_VALOR  = 3'b011,
    VERIFICA_JOGO = 3'b100,
    FIM_JOGO      = 3'b101
  } estado_t;

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   T_LIMITE = TW'(TIMEOUT - 1);
  localparam logic [2:0]      ERR_MAX  = 3'(MAX_ERROS);
  localparam logic [6:0]      JOG_MAX  = 7'd81;

  estado_t       estado;
  logic [TW-1:0] timer;
  logic          digito_ok;
  logic [2:0]    erros_next;

  assign estadoJogo = estado;
  assign digito_ok  = (entrada != 4'd0) && (entrada <= 4'd9);
  assign erros_next = {1'b0, erros} + 3'd1;

  // Handshake: entradaValida and the *Pronto strobes are single-cycle qualifiers,
  // sampled only in the state that consumes them; there is no backpressure.
  always_ff @(posedge clk) begin
    if (reset || (estado == FIM_JOGO && novoJogo)) begin
      estado          <= RECEBE_LINHA;
      linha           <= '0;
      coluna          <= '0;
      valor           <= '0;
      erros           <= '0;
      jogadas         <= '0;
      timer           <= '0;
      escreveCelula   <= 1'b0;
      entradaInvalida <= 1'b0;
      erroTimeout     <= 1'b0;
      vitoria         <= 1'b0;
      derrota         <= 1'b0;
    end else begin
      escreveCelula   <= 1'b0;
      entradaInvalida <= 1'b0;
      erroTimeout     <= 1'b0;
      case (estado)
        RECEBE_LINHA: if (entradaValida) begin
          if (digito_ok) begin
            linha  <= entrada;
            estado <= RECEBE_COLUNA;
          end else entradaInvalida <= 1'b1;
        end
        RECEBE_COLUNA: if (entradaValida) begin
          if (digito_ok) begin
            coluna <= entrada;
            estado <= VERIFICA_POS;
            timer  <= '0;
          end else entradaInvalida <= 1'b1;
        end
        VERIFICA_POS: begin
          // A result arriving on the last waiting cycle wins over the timeout.
          if (verificaPosPronto) begin
            estado <= posLivre ? RECEBE_VALOR : RECEBE_LINHA;
          end else if (timer == T_LIMITE) begin
            estado      <= RECEBE_LINHA;
            erroTimeout <= 1'b1;
          end else timer <= timer + 1'b1;
        end
        RECEBE_VALOR: if (entradaValida) begin
          if (digito_ok) begin
            valor  <= entrada;
            estado <= VERIFICA_JOGO;
            timer  <= '0;
          end else entradaInvalida <= 1'b1;
        end
        VERIFICA_JOGO: begin
          if (verificaJogoPronto) begin
            if (jogadaValida) begin
              escreveCelula <= 1'b1;
              if (jogadas != JOG_MAX) jogadas <= jogadas + 1'b1;
              if (tabuleiroCompleto) begin
                estado  <= FIM_JOGO;
                vitoria <= 1'b1;
              end else estado <= RECEBE_LINHA;
            end else if (erros_next >= ERR_MAX) begin
              erros   <= ERR_MAX[1:0];
              estado  <= FIM_JOGO;
              derrota <= 1'b1;
            end else begin
              erros  <= erros_next[1:0];
              estado <= RECEBE_LINHA;
            end
          end else if (timer == T_LIMITE) begin
            estado      <= RECEBE_LINHA;
            erroTimeout <= 1'b1;
          end else timer <= timer + 1'b1;
        end
        FIM_JOGO: ;
        default: estado <= RECEBE_LINHA;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_jogo.sv
// Bench for controle_jogo: vector table, hand-written corner sequences and
// random stimulus, all checked against a rule-level game model.
module tb_controle_jogo;
  localparam int TIMEOUT   = 16;
  localparam int MAX_ERROS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entradaValida = 1'b0;
  logic [3:0] entrada = '0;
  logic       novoJogo = 1'b0;
  logic       verificaPosPronto = 1'b0;
  logic       posLivre = 1'b0;
  logic       verificaJogoPronto = 1'b0;
  logic       jogadaValida = 1'b0;
  logic       tabuleiroCompleto = 1'b0;
  logic [2:0] estadoJogo;
  logic [3:0] linha, coluna, valor;
  logic       escreveCelula, entradaInvalida, erroTimeout;
  logic [1:0] erros;
  logic [6:0] jogadas;
  logic       vitoria, derrota;

  always #5 clk = ~clk;

  controle_jogo #(.TIMEOUT(TIMEOUT), .MAX_ERROS(MAX_ERROS)) dut (
    .clk(clk), .reset(reset), .entradaValida(entradaValida), .entrada(entrada),
    .novoJogo(novoJogo), .verificaPosPronto(verificaPosPronto), .posLivre(posLivre),
    .verificaJogoPronto(verificaJogoPronto), .jogadaValida(jogadaValida),
    .tabuleiroCompleto(tabuleiroCompleto), .estadoJogo(estadoJogo), .linha(linha),
    .coluna(coluna), .valor(valor), .escreveCelula(escreveCelula),
    .entradaInvalida(entradaInvalida), .erroTimeout(erroTimeout), .erros(erros),
    .jogadas(jogadas), .vitoria(vitoria), .derrota(derrota)
  );

  int checks = 0;
  int failures = 0;

  // Model: phase = step of the move being entered (0 row, 1 col, 2 cell check,
  // 3 digit, 4 move check, 5 game over); waited = cycles spent in a check step.
  typedef struct {
    int phase, linha, coluna, valor, erros, jogadas, waited;
    int inv, esc, tmo, vit, der;
  } model_t;
  model_t m;

  typedef struct {
    int ev, ent, nj, pp, pl, jp, jv, tc;
    int est, inv, esc, er, jog, der;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    int ok;
    ok = (entrada >= 1 && entrada <= 9) ? 1 : 0;
    m.inv = 0; m.esc = 0; m.tmo = 0;
    if (reset || (m.phase == 5 && novoJogo)) begin
      m = '{default: 0};
      return;
    end
    case (m.phase)
      0, 1, 3: if (entradaValida) begin
        if (ok == 0) m.inv = 1;
        else begin
          if (m.phase == 0) m.linha = int'(entrada);
          if (m.phase == 1) m.coluna = int'(entrada);
          if (m.phase == 3) m.valor = int'(entrada);
          m.phase = m.phase + 1;
          m.waited = 0;
        end
      end
      2: begin
        m.waited++;
        if (verificaPosPronto) m.phase = posLivre ? 3 : 0;
        else if (m.waited == TIMEOUT) begin m.phase = 0; m.tmo = 1; end
      end
      4: begin
        m.waited++;
        if (verificaJogoPronto) begin
          if (jogadaValida) begin
            m.esc = 1;
            m.jogadas = (m.jogadas < 81) ? m.jogadas + 1 : 81;
            if (tabuleiroCompleto) begin m.phase = 5; m.vit = 1; end
            else m.phase = 0;
          end else begin
            m.erros++;
            if (m.erros == MAX_ERROS) begin m.phase = 5; m.der = 1; end
            else m.phase = 0;
          end
        end else if (m.waited == TIMEOUT) begin
          m.phase = 0; m.tmo = 1;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic compare_model();
    chk("estadoJogo", int'(estadoJogo), m.phase);
    chk("linha", int'(linha), m.linha);
    chk("coluna", int'(coluna), m.coluna);
    chk("valor", int'(valor), m.valor);
    chk("erros", int'(erros), m.erros);
    chk("jogadas", int'(jogadas), m.jogadas);
    chk("entradaInvalida", int'(entradaInvalida), m.inv);
    chk("escreveCelula", int'(escreveCelula), m.esc);
    chk("erroTimeout", int'(erroTimeout), m.tmo);
    chk("vitoria", int'(vitoria), m.vit);
    chk("derrota", int'(derrota), m.der);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic drive(input int ev, input int ent, input int nj, input int pp,
                       input int pl, input int jp, input int jv, input int tc);
    entradaValida = ev[0]; entrada = 4'(ent); novoJogo = nj[0];
    verificaPosPronto = pp[0]; posLivre = pl[0];
    verificaJogoPronto = jp[0]; jogadaValida = jv[0]; tabuleiroCompleto = tc[0];
  endtask

  task automatic idle_tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic digit(input int d);
    drive(1, d, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic move(input int l, input int c, input int v, input int jv, input int tc);
    digit(l);
    digit(c);
    drive(0, 0, 0, 1, 1, 0, 0, 0); tick();
    digit(v);
    drive(0, 0, 0, 0, 0, 1, jv, tc); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic void add(input int ev, input int ent, input int nj, input int pp,
                              input int pl, input int jp, input int jv, input int tc,
                              input int est, input int inv, input int esc,
                              input int er, input int jog, input int der);
    vecs.push_back('{ev, ent, nj, pp, pl, jp, jv, tc, est, inv, esc, er, jog, der});
  endfunction

  initial begin
    // Accepted move 3,5,7.
    add(1, 3, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1 - 1, 0);
    add(1, 5, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0,  3, 0, 0, 0, 0, 0);
    add(1, 7, 0, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    // Out-of-range digits in recebeLinha.
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0);
    add(1, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    // Occupied cell returns to recebeLinha without an error.
    add(1, 2, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    // Three rejected moves end the game; novoJogo restarts.
    for (int k = 1; k <= 3; k++) begin
      add(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, k - 1, 1, 0);
      add(1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, k - 1, 1, 0);
      add(0, 0, 0, 1, 1, 0, 0, 0, 3, 0, 0, k - 1, 1, 0);
      add(1, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, k - 1, 1, 0);
      add(0, 0, 0, 0, 0, 1, 0, 0, (k == 3) ? 5 : 0, 0, 0, k, 1, (k == 3) ? 1 : 0);
    end
    add(1, 4, 0, 0, 0, 0, 0, 0,  5, 0, 0, 3, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    do_reset();
    chk("reset_estado", int'(estadoJogo), 0);
    chk("reset_jogadas", int'(jogadas), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ev, vecs[i].ent, vecs[i].nj, vecs[i].pp, vecs[i].pl,
            vecs[i].jp, vecs[i].jv, vecs[i].tc);
      tick();
      chk($sformatf("vec%0d_estado", i), int'(estadoJogo), vecs[i].est);
      chk($sformatf("vec%0d_inv", i), int'(entradaInvalida), vecs[i].inv);
      chk($sformatf("vec%0d_esc", i), int'(escreveCelula), vecs[i].esc);
      chk($sformatf("vec%0d_erros", i), int'(erros), vecs[i].er);
      chk($sformatf("vec%0d_jogadas", i), int'(jogadas), vecs[i].jog);
      chk($sformatf("vec%0d_derrota", i), int'(derrota), vecs[i].der);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Position check timeout: 15 cycles waiting, then erroTimeout.
    do_reset();
    digit(4); digit(6);
    for (int k = 1; k < TIMEOUT; k++) idle_tick();
    chk("tmo_still_waiting", int'(estadoJogo), 2);
    idle_tick();
    chk("tmo_estado", int'(estadoJogo), 0);
    chk("tmo_pulse", int'(erroTimeout), 1);
    chk("tmo_erros", int'(erros), 0);

    // Result arriving on the final waiting cycle is honoured.
    digit(4); digit(6);
    for (int k = 1; k < TIMEOUT; k++) idle_tick();
    drive(0, 0, 0, 1, 1, 0, 0, 0); tick();
    chk("late_pronto_estado", int'(estadoJogo), 3);
    chk("late_pronto_tmo", int'(erroTimeout), 0);
    digit(8);
    for (int k = 1; k <= TIMEOUT; k++) idle_tick();
    chk("tmo_jogo_estado", int'(estadoJogo), 0);
    chk("tmo_jogo_pulse", int'(erroTimeout), 1);

    // Reset while in verificaJogo clears counters.
    move(1, 1, 1, 1, 0);
    move(2, 2, 2, 0, 0);
    digit(3); digit(3);
    drive(0, 0, 0, 1, 1, 0, 0, 0); tick();
    digit(3);
    chk("pre_reset_estado", int'(estadoJogo), 4);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_estado", int'(estadoJogo), 0);
    chk("mid_reset_jogadas", int'(jogadas), 0);
    chk("mid_reset_erros", int'(erros), 0);
    chk("mid_reset_esc", int'(escreveCelula), 0);

    // Victory on the 81st accepted move.
    for (int k = 0; k < 80; k++) move(k % 9 + 1, (k / 9) % 9 + 1, (k * 7) % 9 + 1, 1, 0);
    chk("jogadas_80", int'(jogadas), 80);
    move(9, 9, 5, 1, 1);
    chk("vit_estado", int'(estadoJogo), 5);
    chk("vit_flag", int'(vitoria), 1);
    chk("vit_jogadas", int'(jogadas), 81);
    digit(2);
    chk("fim_ignora_estado", int'(estadoJogo), 5);
    chk("fim_ignora_linha", int'(linha), 9);
    drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
    chk("novo_jogo_estado", int'(estadoJogo), 0);
    chk("novo_jogo_vit", int'(vitoria), 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 15), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0));
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
